div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  request offered.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 SHALL have port op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have ports a_i, b_i  input  XLEN  dividend, divisor.
REQ-008 SHALL have port flush_i  input  1  abort current operation.
REQ-009 SHALL have ports rsp_valid_o output 1, rsp_data_o output XLEN, rsp_ready_i input 1  response handshake.
REQ-010 SHALL have ports div_a_o, div_b_o  output  XLEN  unsigned operands to divider.
REQ-011 SHALL have ports div_req_o output 1, div_is_q_o output 1  divider request, 1 = quotient, 0 = remainder.
REQ-012 SHALL have ports div_result_i input XLEN, div_ready_i input 1  divider result and one-cycle done pulse.

Function
REQ-013 SHALL implement states IDLE, ISSUE, FIX, RESP.
REQ-014 SHALL drive req_ready_o = (state==IDLE) & ~flush_i; acceptance latches op, a, b.
REQ-015 SHALL, for signed ops, set div_a_o/div_b_o to the absolute values of a/b; for unsigned ops, pass them unchanged.
REQ-016 SHALL treat as special, with no divider use: b==0 (DIV/DIVU -> all ones, REM/REMU -> a); a==0 (result 0); DIV/REM with a==1<<(XLEN-1) and b==all ones (DIV -> a, REM -> 0).
REQ-017 SHALL, on a special request, go IDLE->RESP with rsp_valid_o high the cycle after acceptance.
REQ-018 SHALL, on a non-special request, go IDLE->ISSUE with div_req_o = (state==ISSUE), held high with stable operands and div_is_q_o until div_ready_i.
REQ-019 SHALL, on div_ready_i in ISSUE, capture div_result_i, go to FIX and drop div_req_o the next cycle.
REQ-020 SHALL, in FIX, negate the captured value when DIV and sign(a)^sign(b), or REM and sign(a); then go to RESP.
REQ-021 SHALL assert rsp_valid_o 2 cycles after the div_ready_i cycle.
REQ-022 SHALL hold rsp_valid_o and a stable rsp_data_o in RESP until rsp_ready_i, then return to IDLE.
REQ-023 SHALL ignore div_ready_i outside ISSUE.
REQ-024 SHALL, on flush_i in any state, go to IDLE next cycle, drop div_req_o and rsp_valid_o, and produce no response; flush wins over a simultaneous req_valid_i.
REQ-025 SHALL truncate all arithmetic to XLEN bits; negation is two's complement.

Reset
REQ-026 SHALL, while rst_i is low, force state IDLE and set rsp_valid_o=0, div_req_o=0, rsp_data_o=0, div_a_o=0, div_b_o=0 and div_is_q_o=0; req_ready_o=1 follows once reset releases.
REQ-027 SHALL treat reset during ISSUE like flush: no response, divider request dropped immediately.

Configuration
REQ-028 SHALL, with macro DIV_CTRL_REUSE_EN defined, keep the last completed {op, a, b, result} with a valid bit, cleared by reset and flush_i.
REQ-029 SHALL, with DIV_CTRL_REUSE_EN defined, serve an accepted request matching the stored op, a and b as special: IDLE->RESP, no divider use.
REQ-030 SHALL, without DIV_CTRL_REUSE_EN, contain no reuse storage; every non-special request uses the divider.

Verification
REQ-031 SHALL cover: DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; div_a_o=7, div_b_o=2 during ISSUE.
REQ-032 SHALL cover: DIVU a=100 b=0 -> 0xFFFFFFFF one cycle after acceptance, div_req_o never high; REMU a=100 b=0 -> 100.
REQ-033 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; divider unused.
REQ-034 SHALL cover: DIVU 10/3 with rsp_ready_i low 5 cycles -> rsp_data_o=3 stable, req_ready_o low until the handshake.
REQ-035 SHALL cover: flush_i 10 cycles into ISSUE -> div_req_o low next cycle, no rsp_valid_o; following REMU 10/3 -> 1.
REQ-036 SHALL cover: rst_i low mid-ISSUE -> outputs at reset values; with DIV_CTRL_REUSE_EN, repeated REMU 10/3 -> 1 one cycle after acceptance, no div_req_o.

Source files
------------

// File: rtl/div_ctrl.sv
// Divide/remainder sequencer: sign handling, special-case shortcuts and handshake around an unsigned divider.
// Optional DIV_CTRL_REUSE_EN keeps the last divider result and answers a repeated request without the divider.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | divider request held until done pulse
// FIX   | apply sign correction to the divider result
// RESP  | response held until rsp_ready_i
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_req_o,
  output logic            div_is_q_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_ready_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, FIX, RESP} state_t;

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] res_q, div_a_q, div_b_q;
  logic            div_is_q_q;

  logic            in_signed, in_rem, accept, special, reuse_hit, neg_fix;
  logic [XLEN-1:0] a_abs, b_abs, special_res, reuse_res, res_fixed;

  assign in_signed = ~op_i[0];
  assign in_rem    = op_i[1];
  assign a_abs     = (in_signed && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_abs     = (in_signed && b_i[XLEN-1]) ? -b_i : b_i;

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign div_req_o   = (state_q == ISSUE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = res_q;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;
  assign div_is_q_o  = div_is_q_q;

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (b_i == '0) begin
      special_res = in_rem ? a_i : '1;
    end else if (a_i == '0) begin
      special_res = '0;
    end else if (in_signed && (a_i == INT_MIN) && (b_i == '1)) begin
      special_res = in_rem ? '0 : a_i;
    end else if (reuse_hit) begin
      special_res = reuse_res;
    end else begin
      special = 1'b0;
    end
  end

  // Divider magnitude is corrected here: quotient takes sign(a)^sign(b), remainder follows the dividend.
  always_comb begin
    neg_fix = 1'b0;
    if (op_q == OP_DIV) neg_fix = sign_a_q ^ sign_b_q;
    else if (op_q == OP_REM) neg_fix = sign_a_q;
  end
  assign res_fixed = neg_fix ? -res_q : res_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = special ? RESP : ISSUE;
      ISSUE: if (div_ready_i) state_d = FIX;
      FIX:   state_d = RESP;
      RESP:  if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      res_q      <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_is_q_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_i;
        sign_a_q   <= in_signed && a_i[XLEN-1];
        sign_b_q   <= in_signed && b_i[XLEN-1];
        div_a_q    <= a_abs;
        div_b_q    <= b_abs;
        div_is_q_q <= ~in_rem;
        if (special) res_q <= special_res;
      end
      if ((state_q == ISSUE) && div_ready_i) res_q <= div_result_i;
      if (state_q == FIX) res_q <= res_fixed;
    end
  end

`ifdef DIV_CTRL_REUSE_EN
  logic [1:0]      op_r;
  logic [XLEN-1:0] a_q, b_q, a_r, b_r, res_r;
  logic            reuse_vld_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      reuse_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (flush_i) begin
        reuse_vld_q <= 1'b0;
      end else if (state_q == FIX) begin
        op_r        <= op_q;
        a_r         <= a_q;
        b_r         <= b_q;
        res_r       <= res_fixed;
        reuse_vld_q <= 1'b1;
      end
    end
  end

  assign reuse_hit = reuse_vld_q && (op_i == op_r) && (a_i == a_r) && (b_i == b_r);
  assign reuse_res = res_r;
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural unsigned divider of programmable latency.
module tb_div_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] div_a_o, div_b_o;
  logic        div_req_o, div_is_q_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;

  div_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_req_o(div_req_o), .div_is_q_o(div_is_q_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Divider model: pulses ready after div_lat cycles of continuous request.
  int div_lat = 3;
  int div_cnt;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt      <= 0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
    end else begin
      div_ready_i <= 1'b0;
      if (div_req_o) begin
        if (div_cnt >= div_lat - 1) begin
          div_ready_i  <= 1'b1;
          div_result_i <= (div_b_o == 0) ? '1 :
                          (div_is_q_o ? div_a_o / div_b_o : div_a_o % div_b_o);
          div_cnt      <= 0;
        end else begin
          div_cnt <= div_cnt + 1;
        end
      end else begin
        div_cnt <= 0;
      end
    end
  end

  int          cyc = 0;
  int          req_cycles = 0, rsp_cnt = 0, rdy_cyc = 0, vld_cyc = 0;
  logic        rsp_prev = 1'b0;
  logic [31:0] seen_a = '0, seen_b = '0;
  logic        seen_isq = 1'b0;

  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    if (div_req_o) begin
      req_cycles++;
      seen_a   = div_a_o;
      seen_b   = div_b_o;
      seen_isq = div_is_q_o;
    end
    if (div_ready_i) rdy_cyc = cyc;
    if (rsp_valid_o && !rsp_prev) vld_cyc = cyc;
    if (rsp_valid_o) rsp_cnt++;
    rsp_prev = rsp_valid_o;
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] data, output int lat, output int nreq);
    req_cycles = 0;
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    data = rsp_data_o;
    nreq = req_cycles;
    if (!rsp_valid_o) begin
      check("rsp_timeout", 32'(rsp_valid_o), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_data", rsp_data_o, data);
      check("hold_req_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  logic [31:0] d;
  int lat, nreq;

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_div_req", 32'(div_req_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);

    // Signed divide/remainder through the divider
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, d, lat, nreq);
    check("div_neg7_2", d, 32'hFFFF_FFFD);
    check("div_a_abs", seen_a, 32'd7);
    check("div_b_abs", seen_b, 32'd2);
    check("div_is_q", 32'(seen_isq), 32'd1);
    check("div_ready_to_rsp", 32'(vld_cyc - rdy_cyc), 32'd2);
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 0, d, lat, nreq);
    check("rem_neg7_2", d, 32'hFFFF_FFFF);
    check("rem_is_q", 32'(seen_isq), 32'd0);
    run_op(DIV, 32'd20, 32'hFFFF_FFFD, 0, d, lat, nreq);
    check("div_20_neg3", d, 32'hFFFF_FFFA);
    run_op(REM, 32'd20, 32'hFFFF_FFFD, 0, d, lat, nreq);
    check("rem_20_neg3", d, 32'd2);

    // Special cases: one cycle after acceptance, divider untouched
    run_op(DIVU, 32'd100, 32'd0, 0, d, lat, nreq);
    check("divu_by0", d, 32'hFFFF_FFFF);
    check("divu_by0_lat", 32'(lat), 32'd1);
    check("divu_by0_nreq", 32'(nreq), 32'd0);
    run_op(REMU, 32'd100, 32'd0, 0, d, lat, nreq);
    check("remu_by0", d, 32'd100);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, d, lat, nreq);
    check("div_ovf", d, 32'h8000_0000);
    check("div_ovf_nreq", 32'(nreq), 32'd0);
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, d, lat, nreq);
    check("rem_ovf", d, 32'd0);
    check("rem_ovf_nreq", 32'(nreq), 32'd0);
    run_op(DIV, 32'd0, 32'd5, 0, d, lat, nreq);
    check("div_a0", d, 32'd0);
    check("div_a0_lat", 32'(lat), 32'd1);

    // Back-pressure on the response
    run_op(DIVU, 32'd10, 32'd3, 5, d, lat, nreq);
    check("divu_10_3", d, 32'd3);

    // Flush 10 cycles into ISSUE
    div_lat = 30;
    @(negedge clk_i);
    op_i = DIVU; a_i = 32'd1000; b_i = 32'd7; req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("flush_pre_req", 32'(div_req_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_div_req", 32'(div_req_o), 32'd0);
    rsp_cnt = 0;
    repeat (40) @(negedge clk_i);
    check("flush_no_rsp", 32'(rsp_cnt), 32'd0);
    div_lat = 3;
    run_op(REMU, 32'd10, 32'd3, 0, d, lat, nreq);
    check("remu_after_flush", d, 32'd1);

    // Flush beats a simultaneous request
    @(negedge clk_i);
    flush_i = 1'b1; req_valid_i = 1'b1; op_i = DIVU; a_i = 32'd10; b_i = 32'd3;
    #1;
    check("flush_req_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0; req_valid_i = 1'b0;
    check("flush_req_no_issue", 32'(div_req_o), 32'd0);
    check("flush_req_no_rsp", 32'(rsp_valid_o), 32'd0);

    // Reset in the middle of ISSUE
    div_lat = 30;
    @(negedge clk_i);
    op_i = DIV; a_i = 32'hFFFF_FFF9; b_i = 32'd2; req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_rst_div_a", div_a_o, 32'd7);
    rst_i = 1'b0;
    #1;
    check("mid_rst_div_req", 32'(div_req_o), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_rsp_data", rsp_data_o, 32'd0);
    check("mid_rst_div_a", div_a_o, 32'd0);
    check("mid_rst_div_b", div_b_o, 32'd0);
    check("mid_rst_div_is_q", 32'(div_is_q_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    div_lat = 3;
    @(negedge clk_i);
    check("post_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);

    run_op(REMU, 32'd10, 32'd3, 0, d, lat, nreq);
    check("remu_first", d, 32'd1);
    check("remu_first_used_div", 32'(nreq != 0), 32'd1);
    run_op(REMU, 32'd10, 32'd3, 0, d, lat, nreq);
    check("remu_repeat", d, 32'd1);
`ifdef DIV_CTRL_REUSE_EN
    check("reuse_lat", 32'(lat), 32'd1);
    check("reuse_nreq", 32'(nreq), 32'd0);
`else
    check("no_reuse_used_div", 32'(nreq != 0), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
